// File: rtl/pattern_detector.sv
// Pattern detector: flags words equal to a loadable pattern and pulses detect after RUN_LEN consecutive matches.
// Optional feature: define DETECT_MASK_EN to enable the compare-mask register fed by cfg_mask.
module pattern_detector #(
  parameter int               WIDTH         = 16,
  parameter logic [WIDTH-1:0] RESET_PATTERN = 1035,
  parameter int               RUN_LEN       = 3,
  parameter int               CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic [WIDTH-1:0] cfg_mask,
  output logic             match,
  output logic             detect,
  output logic [CNT_W-1:0] match_count,
  output logic [7:0]       run_len
);

  // Handshake: in_valid qualifies in_data for one cycle; there is no ready, every valid word is consumed.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HIT  = 2'd2;

  localparam logic [7:0]       RUN_TARGET = 8'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [1:0]       state, state_nxt;
  logic [7:0]       run_q, run_nxt;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] mask;
  logic [CNT_W-1:0] count_q;
  logic             word_hit;

`ifdef DETECT_MASK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask <= '1;
    end else if (cfg_load) begin
      mask <= cfg_mask;
    end
  end
`else
  logic unused_cfg_mask;
  assign unused_cfg_mask = ^cfg_mask;
  assign mask = '1;
`endif

  // Compare uses the pattern currently held, so a word arriving with cfg_load sees the old pattern.
  assign word_hit = in_valid && (((in_data ^ pattern) & mask) == '0);

  always_comb begin
    state_nxt = state;
    run_nxt   = run_q;
    case (state)
      IDLE: begin
        if (word_hit) begin
          run_nxt   = 8'd1;
          state_nxt = (RUN_TARGET == 8'd1) ? HIT : RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          if (word_hit) begin
            run_nxt   = run_q + 8'd1;
            state_nxt = (run_nxt >= RUN_TARGET) ? HIT : RUN;
          end else begin
            run_nxt   = 8'd0;
            state_nxt = IDLE;
          end
        end
      end
      HIT: begin
        // Runs do not overlap: a match straight after a hit starts a fresh run.
        if (word_hit) begin
          run_nxt   = 8'd1;
          state_nxt = RUN;
        end else begin
          run_nxt   = 8'd0;
          state_nxt = IDLE;
        end
      end
      default: begin
        run_nxt   = 8'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pattern <= RESET_PATTERN;
      state   <= IDLE;
      run_q   <= 8'd0;
      count_q <= '0;
      match   <= 1'b0;
    end else begin
      match <= word_hit;
      if (cfg_load) begin
        pattern <= cfg_pattern;
        state   <= IDLE;
        run_q   <= 8'd0;
        count_q <= '0;
      end else begin
        state <= state_nxt;
        run_q <= run_nxt;
        if (word_hit && (count_q != CNT_MAX)) begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  assign detect      = (state == HIT);
  assign match_count = count_q;
  assign run_len     = run_q;

endmodule
